// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolved-outcome update bundle for branch_predictor.
// master = datapath (drives pc / update_*), slave = predictor.
interface branch_predictor_if #(
    parameter int unsigned WORD_SIZE = 16
) ();
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] next_pc;
    logic                 pred_taken;

    logic                 update_en;
    logic [WORD_SIZE-1:0] update_pc;
    logic                 update_is_branch;
    logic                 update_taken;
    logic [WORD_SIZE-1:0] update_target;
    logic                 update_miss;

    logic [WORD_SIZE-1:0] num_branch;
    logic [WORD_SIZE-1:0] num_branch_miss;

    modport master (
        output pc,
        output update_en,
        output update_pc,
        output update_is_branch,
        output update_taken,
        output update_target,
        output update_miss,
        input  next_pc,
        input  pred_taken,
        input  num_branch,
        input  num_branch_miss
    );

    modport slave (
        input  pc,
        input  update_en,
        input  update_pc,
        input  update_is_branch,
        input  update_taken,
        input  update_target,
        input  update_miss,
        output next_pc,
        output pred_taken,
        output num_branch,
        output num_branch_miss
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counter and branch statistics.
// BP_HYSTERESIS_EN selects 2-bit saturating counters; otherwise 1-bit last-outcome.
module branch_predictor #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned INDEX_BITS = 8
) (
    input logic               clk,
    input logic               reset_n,
    branch_predictor_if.slave bp
);

    localparam int unsigned TAG_BITS = WORD_SIZE - INDEX_BITS;
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

`ifdef BP_HYSTERESIS_EN
    localparam int unsigned         CTR_BITS     = 2;
    localparam logic [CTR_BITS-1:0] CTR_RESET    = 2'b01;
    localparam logic [CTR_BITS-1:0] CTR_ALLOC_BR = 2'b10;
`else
    localparam int unsigned         CTR_BITS     = 1;
    localparam logic [CTR_BITS-1:0] CTR_RESET    = 1'b0;
    localparam logic [CTR_BITS-1:0] CTR_ALLOC_BR = 1'b1;
`endif
    localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]  CTR_MIN  = '0;
    localparam logic [WORD_SIZE-1:0] WORD_ONE = WORD_SIZE'(1);

    // Table state
    logic [ENTRIES-1:0]   valid_q, valid_d;
    logic [CTR_BITS-1:0]  ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0]  ctr_d    [ENTRIES];
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [TAG_BITS-1:0]  tag_d    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [WORD_SIZE-1:0] target_d [ENTRIES];

    logic [WORD_SIZE-1:0] num_branch_q, num_branch_d;
    logic [WORD_SIZE-1:0] num_branch_miss_q, num_branch_miss_d;

    // Lookup
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  lk_hit;
    logic                  lk_taken;

    always_comb begin
        lk_idx   = bp.pc[INDEX_BITS-1:0];
        lk_tag   = bp.pc[WORD_SIZE-1:INDEX_BITS];
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    end

    assign bp.next_pc    = lk_taken ? target_q[lk_idx] : (bp.pc + WORD_ONE);
    assign bp.pred_taken = lk_taken;

    // Update decode
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic                  up_taken;
    logic [CTR_BITS-1:0]   up_ctr_cur;
    logic [CTR_BITS-1:0]   up_ctr_trained;

    always_comb begin
        up_idx     = bp.update_pc[INDEX_BITS-1:0];
        up_tag     = bp.update_pc[WORD_SIZE-1:INDEX_BITS];
        up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        // Jumps always count as taken regardless of update_taken.
        up_taken   = !bp.update_is_branch || bp.update_taken;
        up_ctr_cur = ctr_q[up_idx];
    end

    always_comb begin
`ifdef BP_HYSTERESIS_EN
        up_ctr_trained = up_ctr_cur;
        if (bp.update_taken) begin
            if (up_ctr_cur != CTR_MAX) begin
                up_ctr_trained = up_ctr_cur + CTR_BITS'(1);
            end
        end else begin
            if (up_ctr_cur != CTR_MIN) begin
                up_ctr_trained = up_ctr_cur - CTR_BITS'(1);
            end
        end
`else
        up_ctr_trained = bp.update_taken;
`endif
    end

    // Next-state for the table and the statistics counters
    always_comb begin
        valid_d           = valid_q;
        ctr_d             = ctr_q;
        tag_d             = tag_q;
        target_d          = target_q;
        num_branch_d      = num_branch_q;
        num_branch_miss_d = num_branch_miss_q;

        if (bp.update_en) begin
            if (up_hit) begin
                target_d[up_idx] = bp.update_target;
                ctr_d[up_idx]    = bp.update_is_branch ? up_ctr_trained : CTR_MAX;
            end else if (up_taken) begin
                // Allocation evicts whatever occupied this index.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bp.update_target;
                ctr_d[up_idx]    = bp.update_is_branch ? CTR_ALLOC_BR : CTR_MAX;
            end

            if (bp.update_is_branch) begin
                num_branch_d = num_branch_q + WORD_ONE;
                if (bp.update_miss) begin
                    num_branch_miss_d = num_branch_miss_q + WORD_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q           <= '0;
            num_branch_q      <= '0;
            num_branch_miss_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i]    <= CTR_RESET;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            valid_q           <= valid_d;
            ctr_q             <= ctr_d;
            tag_q             <= tag_d;
            target_q          <= target_d;
            num_branch_q      <= num_branch_d;
            num_branch_miss_q <= num_branch_miss_d;
        end
    end

    assign bp.num_branch      = num_branch_q;
    assign bp.num_branch_miss = num_branch_miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; expected values follow
// the BP_HYSTERESIS_EN setting of the build.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predictor_if #(.WORD_SIZE(16)) bp_if ();

    branch_predictor #(
        .WORD_SIZE (16),
        .INDEX_BITS(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bp     (bp_if)
    );

`ifdef BP_HYSTERESIS_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    task automatic idle_inputs();
        bp_if.update_en        = 1'b0;
        bp_if.update_pc        = 16'h0000;
        bp_if.update_is_branch = 1'b0;
        bp_if.update_taken     = 1'b0;
        bp_if.update_target    = 16'h0000;
        bp_if.update_miss      = 1'b0;
    endtask

    task automatic set_pc(input logic [15:0] p);
        bp_if.pc = p;
        #1;
    endtask

    // One update cycle; returns 1 time unit after the capturing edge.
    task automatic upd(input logic [15:0] upc, input logic br, input logic tk,
                       input logic [15:0] tgt, input logic miss);
        bp_if.update_en        = 1'b1;
        bp_if.update_pc        = upc;
        bp_if.update_is_branch = br;
        bp_if.update_taken     = tk;
        bp_if.update_target    = tgt;
        bp_if.update_miss      = miss;
        @(posedge clk);
        #1;
        bp_if.update_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        set_pc(16'h0040);
        n_tests++;
        if (bp_if.next_pc !== 16'h0041 || bp_if.pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_lookup: next_pc=%h pred=%b, expected 0041/0",
                     bp_if.next_pc, bp_if.pred_taken);
        end
        n_tests++;
        if (bp_if.num_branch !== 16'h0000 || bp_if.num_branch_miss !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_counters: nb=%h nm=%h, expected 0000/0000",
                     bp_if.num_branch, bp_if.num_branch_miss);
        end
        // Update attempted while in reset must leave nothing behind.
        upd(16'h0040, 1'b1, 1'b1, 16'h0123, 1'b1);
        set_pc(16'h0040);
        n_tests++;
        if (bp_if.next_pc !== 16'h0041 || bp_if.num_branch !== 16'h0000 ||
            bp_if.num_branch_miss !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_blocks_update: next_pc=%h nb=%h nm=%h, expected 0041/0000/0000",
                     bp_if.next_pc, bp_if.num_branch, bp_if.num_branch_miss);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bp_if.next_pc !== 16'h0041 || bp_if.pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: next_pc=%h pred=%b, expected 0041/0",
                     bp_if.next_pc, bp_if.pred_taken);
        end
    endtask

    task automatic test_wrap_pc();
        set_pc(16'hFFFF);
        n_tests++;
        if (bp_if.next_pc !== 16'h0000 || bp_if.pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL pc_wrap: next_pc=%h pred=%b, expected 0000/0",
                     bp_if.next_pc, bp_if.pred_taken);
        end
    endtask

    task automatic test_jump_alloc();
        upd(16'h0010, 1'b0, 1'b0, 16'h0080, 1'b0);
        set_pc(16'h0010);
        n_tests++;
        if (bp_if.next_pc !== 16'h0080 || bp_if.pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_hit: next_pc=%h pred=%b, expected 0080/1",
                     bp_if.next_pc, bp_if.pred_taken);
        end
        set_pc(16'h0110);
        n_tests++;
        if (bp_if.next_pc !== 16'h0111 || bp_if.pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_tag_miss: next_pc=%h pred=%b, expected 0111/0",
                     bp_if.next_pc, bp_if.pred_taken);
        end
        n_tests++;
        if (bp_if.num_branch !== 16'h0000) begin
            n_fail++;
            $display("FAIL jump_not_counted: nb=%h, expected 0000", bp_if.num_branch);
        end
        // Retarget on tag match, then evict with a conflicting tag.
        upd(16'h0010, 1'b0, 1'b0, 16'h0090, 1'b0);
        set_pc(16'h0010);
        n_tests++;
        if (bp_if.next_pc !== 16'h0090) begin
            n_fail++;
            $display("FAIL jump_retarget: next_pc=%h, expected 0090", bp_if.next_pc);
        end
        upd(16'h0110, 1'b0, 1'b1, 16'h00A0, 1'b0);
        set_pc(16'h0110);
        n_tests++;
        if (bp_if.next_pc !== 16'h00A0 || bp_if.pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL replace_new: next_pc=%h pred=%b, expected 00a0/1",
                     bp_if.next_pc, bp_if.pred_taken);
        end
        set_pc(16'h0010);
        n_tests++;
        if (bp_if.next_pc !== 16'h0011 || bp_if.pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL replace_old_gone: next_pc=%h pred=%b, expected 0011/0",
                     bp_if.next_pc, bp_if.pred_taken);
        end
    endtask

    task automatic test_hysteresis();
        logic [15:0] exp_pc;
        upd(16'h0020, 1'b1, 1'b1, 16'h0005, 1'b0);
        set_pc(16'h0020);
        n_tests++;
        if (bp_if.next_pc !== 16'h0005) begin
            n_fail++;
            $display("FAIL hyst_alloc: next_pc=%h, expected 0005", bp_if.next_pc);
        end
        upd(16'h0020, 1'b1, 1'b1, 16'h0005, 1'b0);
        n_tests++;
        if (bp_if.next_pc !== 16'h0005) begin
            n_fail++;
            $display("FAIL hyst_tt: next_pc=%h, expected 0005", bp_if.next_pc);
        end
        upd(16'h0020, 1'b1, 1'b0, 16'h0005, 1'b1);
        exp_pc = HYST ? 16'h0005 : 16'h0021;
        n_tests++;
        if (bp_if.next_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL hyst_ttn: next_pc=%h, expected %h", bp_if.next_pc, exp_pc);
        end
        upd(16'h0020, 1'b1, 1'b0, 16'h0005, 1'b0);
        n_tests++;
        if (bp_if.next_pc !== 16'h0021 || bp_if.pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL hyst_ttnn: next_pc=%h pred=%b, expected 0021/0",
                     bp_if.next_pc, bp_if.pred_taken);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_pc;
        bp_if.pc = 16'h0040;
        for (int k = 1; k <= 5; k++) begin
            upd(16'h0040, 1'b1, 1'b1, 16'h0044, 1'b0);
            n_tests++;
            if (bp_if.next_pc !== 16'h0044 || bp_if.pred_taken !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_taken_%0d: next_pc=%h pred=%b, expected 0044/1",
                         k, bp_if.next_pc, bp_if.pred_taken);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            upd(16'h0040, 1'b1, 1'b0, 16'h0044, 1'b0);
            exp_pc = (HYST && k == 1) ? 16'h0044 : 16'h0041;
            n_tests++;
            if (bp_if.next_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL sat_not_taken_%0d: next_pc=%h, expected %h",
                         k, bp_if.next_pc, exp_pc);
            end
        end
        // From a floor of 00 a single taken only reaches 01.
        upd(16'h0040, 1'b1, 1'b1, 16'h0044, 1'b0);
        exp_pc = HYST ? 16'h0041 : 16'h0044;
        n_tests++;
        if (bp_if.next_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL sat_floor_then_taken: next_pc=%h, expected %h", bp_if.next_pc, exp_pc);
        end
        upd(16'h0050, 1'b1, 1'b0, 16'h0099, 1'b0);
        set_pc(16'h0050);
        n_tests++;
        if (bp_if.next_pc !== 16'h0051 || bp_if.pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL nt_no_alloc: next_pc=%h pred=%b, expected 0051/0",
                     bp_if.next_pc, bp_if.pred_taken);
        end
        upd(16'h0050, 1'b1, 1'b1, 16'h0099, 1'b0);
        n_tests++;
        if (bp_if.next_pc !== 16'h0099 || bp_if.pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_alloc: next_pc=%h pred=%b, expected 0099/1",
                     bp_if.next_pc, bp_if.pred_taken);
        end
    endtask

    task automatic test_same_cycle();
        bp_if.pc               = 16'h0030;
        bp_if.update_en        = 1'b1;
        bp_if.update_pc        = 16'h0030;
        bp_if.update_is_branch = 1'b1;
        bp_if.update_taken     = 1'b1;
        bp_if.update_target    = 16'h0077;
        bp_if.update_miss      = 1'b0;
        #1;
        n_tests++;
        if (bp_if.next_pc !== 16'h0031 || bp_if.pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_old: next_pc=%h pred=%b, expected 0031/0",
                     bp_if.next_pc, bp_if.pred_taken);
        end
        @(posedge clk);
        #1;
        bp_if.update_en = 1'b0;
        n_tests++;
        if (bp_if.next_pc !== 16'h0077 || bp_if.pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_next: next_pc=%h pred=%b, expected 0077/1",
                     bp_if.next_pc, bp_if.pred_taken);
        end
    endtask

    task automatic test_counters();
        reset_n = 1'b0;
        set_pc(16'h0030);
        n_tests++;
        if (bp_if.next_pc !== 16'h0031 || bp_if.num_branch !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_clears: next_pc=%h nb=%h, expected 0031/0000",
                     bp_if.next_pc, bp_if.num_branch);
        end
        reset_n = 1'b1;
        upd(16'h0100, 1'b1, 1'b1, 16'h0200, 1'b0);
        upd(16'h0101, 1'b1, 1'b0, 16'h0200, 1'b1);
        upd(16'h0102, 1'b1, 1'b1, 16'h0200, 1'b0);
        upd(16'h0103, 1'b0, 1'b0, 16'h0200, 1'b1);
        upd(16'h0104, 1'b0, 1'b1, 16'h0200, 1'b0);
        n_tests++;
        if (bp_if.num_branch !== 16'd3 || bp_if.num_branch_miss !== 16'd1) begin
            n_fail++;
            $display("FAIL counters: nb=%0d nm=%0d, expected 3/1",
                     bp_if.num_branch, bp_if.num_branch_miss);
        end
    endtask

    task automatic test_counter_wrap();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        bp_if.update_en        = 1'b1;
        bp_if.update_pc        = 16'h0300;
        bp_if.update_is_branch = 1'b1;
        bp_if.update_taken     = 1'b0;
        bp_if.update_target    = 16'h0000;
        bp_if.update_miss      = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        n_tests++;
        if (bp_if.num_branch !== 16'hFFFF || bp_if.num_branch_miss !== 16'h0000) begin
            n_fail++;
            $display("FAIL counter_preload: nb=%h nm=%h, expected ffff/0000",
                     bp_if.num_branch, bp_if.num_branch_miss);
        end
        bp_if.update_miss = 1'b1;
        @(posedge clk);
        #1;
        bp_if.update_en = 1'b0;
        n_tests++;
        if (bp_if.num_branch !== 16'h0000 || bp_if.num_branch_miss !== 16'h0001) begin
            n_fail++;
            $display("FAIL counter_wrap: nb=%h nm=%h, expected 0000/0001",
                     bp_if.num_branch, bp_if.num_branch_miss);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bp_if.num_branch !== 16'h0000) begin
            n_fail++;
            $display("FAIL counter_idle_hold: nb=%h, expected 0000", bp_if.num_branch);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_pc();
        test_jump_alloc();
        test_hysteresis();
        test_saturation();
        test_same_cycle();
        test_counters();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
